cnn_dma_arbiter: RTL
====================

# cnn_dma_arbiter

Round-robin arbiter that shares the single DMA memory port between the CNN requesters: layer-descriptor fetch, convolution loads/writebacks, pooling loads/writebacks, and previous-partial-sum reads. Sits between the layer controller plus the conv/pool engines and the DMA. Each request is one single-word read or write. The block serialises requests, drives the DMA, returns read data and signals completion per requester.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `DATA_SIZE`, 16, data word width.
- `ADDR_SIZE`, 16, address width.
- `TIMEOUT`, 255, maximum `ISSUE` cycles before abort; used only with `DMA_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `reqValid` in NUM_REQ: request pending, one bit per requester.
- `reqWrite` in NUM_REQ: 1 = write, 0 = read.
- `reqLock` in NUM_REQ: keep ownership for a back-to-back request.
- `reqAddr` in NUM_REQ*ADDR_SIZE: flattened; requester i uses bits [i*ADDR_SIZE +: ADDR_SIZE].
- `reqData` in NUM_REQ*DATA_SIZE: flattened write data, same slicing as `reqAddr`.
- `reqGrant` out NUM_REQ: one-hot owner of the current transaction.
- `reqDone` out NUM_REQ: one-cycle completion pulse.
- `rdData` out DATA_SIZE: read data of the last completed transaction.
- `dmaEnable` out 1: transaction active toward the DMA.
- `dmaWrite` out 1: direction of the active transaction.
- `dmaAddress` out ADDR_SIZE: address of the active transaction.
- `dmaInput` out DATA_SIZE: write data.
- `dmaDone` in 1: DMA completion.
- `dmaOutput` in DATA_SIZE: DMA read data, valid with `dmaDone`.
- `busy` out 1: state is not `IDLE`.
- `timeoutErr` out 1: sticky timeout flag.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Reset also sets the internal pointer `lastIdx` to NUM_REQ-1 and clears the lock owner.
- **States:** `IDLE`, `ISSUE`, `DONE`.
- **IDLE** (any `reqValid` set):
  - Selection: if the lock owner is valid and its `reqValid` is high, it is selected. Otherwise the first set bit searching `lastIdx+1 ... lastIdx+NUM_REQ` (mod NUM_REQ) is selected.
  - On selection: latch index, address, data and direction. Set `reqGrant` one-hot, `dmaEnable`=1, `dmaWrite`/`dmaAddress`/`dmaInput` from the latched values. Go to `ISSUE`.
  - `lastIdx` is updated to the selected index.
  - If the lock owner's `reqValid` is low in `IDLE`, the lock is cleared.
- **ISSUE:**
  - Outputs are held stable; later changes on request inputs are ignored.
  - On `dmaDone`=1: `dmaEnable`=0, `reqDone[idx]`=1. For reads, `rdData`=`dmaOutput`; for writes, `rdData` is unchanged. Go to `DONE`.
- **DONE** (one cycle):
  - `reqDone` returns to 0 and `reqGrant` returns to 0.
  - If `reqLock[idx]` is high, the lock owner becomes idx; otherwise the lock is cleared. Go to `IDLE`.
- Requester handshake:
  - A requester must drop `reqValid` in the cycle after its `reqDone` pulse, unless it wants another transaction.
  - `reqValid` still high at the following `IDLE` edge is treated as a new request.
- `dmaDone` is ignored in `IDLE` and `DONE`.
- `busy` = (state != `IDLE`).

## Timing
- Latency from request to DMA: `reqValid` sampled at edge k in `IDLE` gives `dmaEnable`/`reqGrant` high after edge k.
- Completion: `dmaDone` sampled at edge m gives `reqDone` high during m..m+1 and `busy` low after m+1.
- Earliest next grant is at edge m+2. Minimum transaction period is 3 cycles when `dmaDone` is returned in the first `ISSUE` cycle.
- Fairness: with all requesters continuously valid and no lock, each waits at most NUM_REQ-1 transactions.
- Lock can starve others only while the owner keeps both `reqValid` and `reqLock` high.
- Reset mid-transaction (any state): at the next edge all outputs are 0 and the state is `IDLE`. No `reqDone` is issued for the aborted transaction. `timeoutErr` is cleared.

## Configuration
- `DMA_ARB_TIMEOUT_EN` defined:
  - An 8-bit (or wider, to hold TIMEOUT) counter clears on entry to `ISSUE` and increments each `ISSUE` cycle without `dmaDone`.
  - When the counter reaches TIMEOUT: `dmaEnable`=0, `reqDone[idx]` pulses, `rdData`=0, `timeoutErr`=1 (sticky until reset), go to `DONE`.
  - `dmaDone` in the same cycle as the counter reaching TIMEOUT wins: normal completion, no error.
- `DMA_ARB_TIMEOUT_EN` undefined: `ISSUE` waits indefinitely for `dmaDone`. `timeoutErr` is tied to 0 and `TIMEOUT` is unused.

## Test plan
- Single read: requester 2 reads address 0x0040; DMA returns `dmaDone` 3 cycles after `dmaEnable` with 0x1234 -> `reqGrant`=0100, `dmaAddress`=0x0040, `dmaWrite`=0, `reqDone[2]` one-cycle pulse, `rdData`=0x1234.
- Write: requester 0 writes 0xBEEF to 0x0100 -> `dmaWrite`=1, `dmaInput`=0xBEEF, `rdData` unchanged after `reqDone[0]`.
- Round-robin: all four requesters valid right after reset, each dropping `reqValid` after its done and re-raising it two cycles later -> grant order 0,1,2,3,0.
- Lock: requester 1 issues two requests with `reqLock`=1 while requester 3 is pending -> requester 1 is served twice consecutively, then requester 3.
- Reset while `dmaEnable`=1 in `ISSUE` -> next edge `dmaEnable`=0, `reqGrant`=0, no `reqDone`; a new request is granted normally after reset.
- With `DMA_ARB_TIMEOUT_EN`, `TIMEOUT`=8, `dmaDone` never asserted -> after 8 `ISSUE` cycles `reqDone` pulses, `rdData`=0, `timeoutErr`=1 and stays 1 until reset.

Source files
------------

// File: rtl/cnn_dma_arbiter.sv
// Round-robin arbiter sharing one single-word DMA port between CNN requesters.
// Optional ISSUE-phase abort is enabled by defining DMA_ARB_TIMEOUT_EN.
module cnn_dma_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             reqValid,
  input  logic [NUM_REQ-1:0]             reqWrite,
  input  logic [NUM_REQ-1:0]             reqLock,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   reqAddr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   reqData,
  output logic [NUM_REQ-1:0]             reqGrant,
  output logic [NUM_REQ-1:0]             reqDone,
  output logic [DATA_SIZE-1:0]           rdData,
  output logic                           dmaEnable,
  output logic                           dmaWrite,
  output logic [ADDR_SIZE-1:0]           dmaAddress,
  output logic [DATA_SIZE-1:0]           dmaInput,
  input  logic                           dmaDone,
  input  logic [DATA_SIZE-1:0]           dmaOutput,
  output logic                           busy,
  output logic                           timeoutErr
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_idx_q, last_idx_d;
  logic                 lock_valid_q, lock_valid_d;
  logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;

  logic [NUM_REQ-1:0]   grant_d;
  logic [NUM_REQ-1:0]   done_d;
  logic [DATA_SIZE-1:0] rd_data_d;
  logic                 enable_d;
  logic                 write_d;
  logic [ADDR_SIZE-1:0] addr_d;
  logic [DATA_SIZE-1:0] wdata_d;
  logic                 busy_d;

  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  // Requester selection: a live lock owner wins, else first valid after lastIdx.
  always_comb begin
    int unsigned pos;
    sel_found = 1'b0;
    sel_idx   = last_idx_q;
    pos       = 0;
    if (lock_valid_q && reqValid[lock_idx_q]) begin
      sel_found = 1'b1;
      sel_idx   = lock_idx_q;
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        pos = 32'(last_idx_q) + k;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        if (!sel_found && reqValid[pos]) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(pos);
        end
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    grant_d      = reqGrant;
    done_d       = '0;
    rd_data_d    = rdData;
    enable_d     = dmaEnable;
    write_d      = dmaWrite;
    addr_d       = dmaAddress;
    wdata_d      = dmaInput;
`ifdef DMA_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (lock_valid_q && !reqValid[lock_idx_q]) lock_valid_d = 1'b0;
        if (sel_found) begin
          idx_d      = sel_idx;
          last_idx_d = sel_idx;
          grant_d    = NUM_REQ'(1) << sel_idx;
          enable_d   = 1'b1;
          write_d    = reqWrite[sel_idx];
          addr_d     = reqAddr[32'(sel_idx)*ADDR_SIZE +: ADDR_SIZE];
          wdata_d    = reqData[32'(sel_idx)*DATA_SIZE +: DATA_SIZE];
`ifdef DMA_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        if (dmaDone) begin
          enable_d       = 1'b0;
          done_d[idx_q]  = 1'b1;
          if (!dmaWrite) rd_data_d = dmaOutput;
          state_d        = DONE;
        end
`ifdef DMA_ARB_TIMEOUT_EN
        // dmaDone in the same cycle takes priority over the abort.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          enable_d       = 1'b0;
          done_d[idx_q]  = 1'b1;
          rd_data_d      = '0;
          err_d          = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      DONE: begin
        grant_d      = '0;
        lock_valid_d = reqLock[idx_q];
        lock_idx_d   = idx_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      last_idx_q   <= IDX_W'(NUM_REQ - 1);
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
      reqGrant     <= '0;
      reqDone      <= '0;
      rdData       <= '0;
      dmaEnable    <= 1'b0;
      dmaWrite     <= 1'b0;
      dmaAddress   <= '0;
      dmaInput     <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
      reqGrant     <= grant_d;
      reqDone      <= done_d;
      rdData       <= rd_data_d;
      dmaEnable    <= enable_d;
      dmaWrite     <= write_d;
      dmaAddress   <= addr_d;
      dmaInput     <= wdata_d;
      busy         <= busy_d;
    end
  end

`ifdef DMA_ARB_TIMEOUT_EN
  // Issue-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeoutErr = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeoutErr     = 1'b0;
`endif

endmodule
